retro_change_dispenser: RTL and testbench

- Pays change back to the customer as individual coin pulses on three coin-out lines (25, 10 and 5 cents).
- It is the output-side counterpart of the coin inputs on `retro_vending`:
  - The vending controller hands this block a change amount over a valid/ready handshake.
  - The block meters it out greedily from per-denomination inventory counters.
  - It reports completion, including any shortfall it could not pay.

---
 rtl/retro_change_dispenser.sv | 212 +++++++++++++++++++++
 tb/tb_retro_change_dispenser.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/retro_change_dispenser.sv
// ============================================================================
// Module   : retro_change_dispenser
// Purpose  : Greedy 25/10/5 coin change payer with per-denomination stock.
//            Optional abort input enabled by RETRO_CHANGE_ABORT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module retro_change_dispenser #(
    parameter int AMOUNT_W     = 8,
    parameter int INV_W        = 6,
    parameter int INIT_25      = 20,
    parameter int INIT_10      = 20,
    parameter int INIT_5       = 20,
    parameter int PULSE_CYCLES = 2,
    parameter int GAP_CYCLES   = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                change_valid,
    input  logic [AMOUNT_W-1:0] change_amount,
    output logic                change_ready,
    input  logic                refill,
`ifdef RETRO_CHANGE_ABORT_EN
    input  logic                abort,
`endif
    output logic                coin_out_25,
    output logic                coin_out_10,
    output logic                coin_out_5,
    output logic                busy,
    output logic                done,
    output logic                short,
    output logic [AMOUNT_W-1:0] remaining,
    output logic [INV_W-1:0]    inv_25,
    output logic [INV_W-1:0]    inv_10,
    output logic [INV_W-1:0]    inv_5
);

    localparam int CNT_W = 8;
    localparam logic [AMOUNT_W-1:0] c_V25     = AMOUNT_W'(25);
    localparam logic [AMOUNT_W-1:0] c_V10     = AMOUNT_W'(10);
    localparam logic [AMOUNT_W-1:0] c_V5      = AMOUNT_W'(5);
    localparam logic [INV_W-1:0]    c_INV_ONE = INV_W'(1);
    localparam logic [INV_W-1:0]    c_INIT25  = INV_W'(INIT_25);
    localparam logic [INV_W-1:0]    c_INIT10  = INV_W'(INIT_10);
    localparam logic [INV_W-1:0]    c_INIT5   = INV_W'(INIT_5);
    localparam logic [CNT_W-1:0]    c_PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0]    c_GAP_LAST   = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SELECT = 3'd1,
        S_PULSE  = 3'd2,
        S_GAP    = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [AMOUNT_W-1:0]   bal_q, bal_d;
    logic [INV_W-1:0]      inv25_q, inv25_d;
    logic [INV_W-1:0]      inv10_q, inv10_d;
    logic [INV_W-1:0]      inv5_q, inv5_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [2:0]            coin_q, coin_d;     // one-hot {25, 10, 5}
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  short_q, short_d;
    logic [AMOUNT_W-1:0]   rem_q, rem_d;
    logic                  abort_q, abort_d;

    logic w_abort;
    logic w_pick25, w_pick10, w_pick5;

`ifdef RETRO_CHANGE_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    // Greedy priority: a denomination is eligible only if it fits and is in stock.
    assign w_pick25 = (bal_q >= c_V25) && (inv25_q != '0);
    assign w_pick10 = !w_pick25 && (bal_q >= c_V10) && (inv10_q != '0);
    assign w_pick5  = !w_pick25 && !w_pick10 && (bal_q >= c_V5) && (inv5_q != '0);

    always_comb begin
        state_d = state_q;
        bal_d   = bal_q;
        inv25_d = inv25_q;
        inv10_d = inv10_q;
        inv5_d  = inv5_q;
        cnt_d   = cnt_q;
        coin_d  = 3'b000;
        done_d  = 1'b0;
        short_d = 1'b0;
        rem_d   = rem_q;
        abort_d = abort_q;

        case (state_q)
            S_IDLE: begin
                abort_d = 1'b0;
                if (refill) begin
                    inv25_d = c_INIT25;
                    inv10_d = c_INIT10;
                    inv5_d  = c_INIT5;
                end
                if (change_valid) begin
                    bal_d   = change_amount;
                    state_d = S_SELECT;
                end
            end
            S_SELECT: begin
                abort_d = abort_q | w_abort;
                cnt_d   = '0;
                state_d = S_PULSE;
                if (w_pick25) begin
                    bal_d   = bal_q - c_V25;
                    inv25_d = inv25_q - c_INV_ONE;
                    coin_d  = 3'b100;
                end else if (w_pick10) begin
                    bal_d   = bal_q - c_V10;
                    inv10_d = inv10_q - c_INV_ONE;
                    coin_d  = 3'b010;
                end else if (w_pick5) begin
                    bal_d   = bal_q - c_V5;
                    inv5_d  = inv5_q - c_INV_ONE;
                    coin_d  = 3'b001;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_PULSE: begin
                abort_d = abort_q | w_abort;
                if (cnt_q == c_PULSE_LAST) begin
                    cnt_d   = '0;
                    state_d = S_GAP;
                end else begin
                    cnt_d  = cnt_q + 1'b1;
                    coin_d = coin_q;
                end
            end
            S_GAP: begin
                abort_d = abort_q | w_abort;
                if (cnt_q == c_GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = (abort_q || w_abort) ? S_DONE : S_SELECT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                abort_d = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // DONE is only entered from SELECT or GAP, where the balance is not modified.
        if (state_d == S_DONE) begin
            done_d  = 1'b1;
            short_d = (bal_q != '0);
            rem_d   = bal_q;
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            bal_q   <= '0;
            inv25_q <= c_INIT25;
            inv10_q <= c_INIT10;
            inv5_q  <= c_INIT5;
            cnt_q   <= '0;
            coin_q  <= 3'b000;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            short_q <= 1'b0;
            rem_q   <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            bal_q   <= bal_d;
            inv25_q <= inv25_d;
            inv10_q <= inv10_d;
            inv5_q  <= inv5_d;
            cnt_q   <= cnt_d;
            coin_q  <= coin_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            short_q <= short_d;
            rem_q   <= rem_d;
            abort_q <= abort_d;
        end
    end

    assign change_ready = (state_q == S_IDLE) && reset;
    assign coin_out_25  = coin_q[2];
    assign coin_out_10  = coin_q[1];
    assign coin_out_5   = coin_q[0];
    assign busy         = busy_q;
    assign done         = done_q;
    assign short        = short_q;
    assign remaining    = rem_q;
    assign inv_25       = inv25_q;
    assign inv_10       = inv10_q;
    assign inv_5        = inv5_q;

endmodule

`default_nettype wire

// File: tb/tb_retro_change_dispenser.sv
// ============================================================================
// Module   : tb_retro_change_dispenser
// Purpose  : Vector-table and directed-sequence bench for retro_change_dispenser.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_retro_change_dispenser;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       change_valid = 1'b0;
    logic [7:0] change_amount = 8'd0;
    logic       change_ready;
    logic       refill = 1'b0;
`ifdef RETRO_CHANGE_ABORT_EN
    logic       abort = 1'b0;
`endif
    logic       coin_out_25, coin_out_10, coin_out_5;
    logic       busy, done, short;
    logic [7:0] remaining;
    logic [5:0] inv_25, inv_10, inv_5;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    retro_change_dispenser dut (
        .clk          (clk),
        .reset        (reset),
        .change_valid (change_valid),
        .change_amount(change_amount),
        .change_ready (change_ready),
        .refill       (refill),
`ifdef RETRO_CHANGE_ABORT_EN
        .abort        (abort),
`endif
        .coin_out_25  (coin_out_25),
        .coin_out_10  (coin_out_10),
        .coin_out_5   (coin_out_5),
        .busy         (busy),
        .done         (done),
        .short        (short),
        .remaining    (remaining),
        .inv_25       (inv_25),
        .inv_10       (inv_10),
        .inv_5        (inv_5)
    );

    typedef struct {
        logic [7:0] amt;
        bit         rf;
        int         n25, n10, n5;
        bit         sh;
        int         rem;
        int         i25, i10, i5;
    } vec_t;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // Expected greedy pulse order, 2-bit code per coin: 1=25, 2=10, 3=5.
    function automatic logic [23:0] mkseq(input int a, input int b, input int c);
        logic [23:0] s = '0;
        int k = 0;
        for (int i = 0; i < a; i++) begin s[2*k +: 2] = 2'd1; k++; end
        for (int i = 0; i < b; i++) begin s[2*k +: 2] = 2'd2; k++; end
        for (int i = 0; i < c; i++) begin s[2*k +: 2] = 2'd3; k++; end
        return s;
    endfunction

    // Issues one request and observes it until done (bounded).
    task automatic run_txn(input logic [7:0] amt, input bit rf, output bit rdy,
                           output int lat, output logic [23:0] seq, output int n,
                           output bit ok);
        logic [1:0] prev, cur;
        int run;
        lat = -1; seq = '0; n = 0; ok = 1'b1; run = 0; prev = 2'd0;
        @(negedge clk);
        rdy = change_ready;
        change_valid = 1'b1; change_amount = amt; refill = rf;
        @(posedge clk);
        #1 change_valid = 1'b0; refill = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            cur = coin_out_25 ? 2'd1 : coin_out_10 ? 2'd2 : coin_out_5 ? 2'd3 : 2'd0;
            if ($countones({coin_out_25, coin_out_10, coin_out_5}) > 1) ok = 1'b0;
            if (cur != 2'd0 && prev == 2'd0) begin
                if (n < 12) seq[2*n +: 2] = cur;
                if (n == 0 && c != 2) ok = 1'b0;
                n++;
                run = 1;
            end else if (cur != 2'd0 && cur == prev) begin
                run++;
            end else if (cur != 2'd0) begin
                ok = 1'b0;
            end
            if (cur == 2'd0 && prev != 2'd0 && run != 2) ok = 1'b0;
            if (!busy) ok = 1'b0;
            prev = cur;
            if (done) begin lat = c; break; end
        end
    endtask

    vec_t vecs[11];
    bit rdy, ok, all_ok;
    int lat, n, exp_n;
    logic [23:0] seq;

    initial begin
        vecs[0]  = '{8'd40,  1'b0, 1, 1, 1,  1'b0, 0, 19, 19, 19};
        vecs[1]  = '{8'd0,   1'b0, 0, 0, 0,  1'b0, 0, 19, 19, 19};
        vecs[2]  = '{8'd37,  1'b0, 1, 1, 0,  1'b1, 2, 18, 18, 19};
        vecs[3]  = '{8'd3,   1'b0, 0, 0, 0,  1'b1, 3, 18, 18, 19};
        vecs[4]  = '{8'd65,  1'b0, 2, 1, 1,  1'b0, 0, 16, 17, 18};
        vecs[5]  = '{8'd20,  1'b1, 0, 2, 0,  1'b0, 0, 20, 18, 20};
        vecs[6]  = '{8'd255, 1'b0, 10, 0, 1, 1'b0, 0, 10, 18, 19};
        vecs[7]  = '{8'd250, 1'b1, 10, 0, 0, 1'b0, 0, 10, 20, 20};
        vecs[8]  = '{8'd250, 1'b0, 10, 0, 0, 1'b0, 0, 0, 20, 20};
        vecs[9]  = '{8'd30,  1'b0, 0, 3, 0,  1'b0, 0, 0, 17, 20};
        vecs[10] = '{8'd25,  1'b1, 1, 0, 0,  1'b0, 0, 19, 20, 20};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", change_ready, 0);
        chk("rst_coins", {coin_out_25, coin_out_10, coin_out_5}, 0);
        chk("rst_busy_done_short", {busy, done, short}, 0);
        chk("rst_remaining", remaining, 0);
        chk("rst_inv", {inv_25, inv_10, inv_5}, {6'd20, 6'd20, 6'd20});
        reset = 1'b1;
        @(negedge clk);
        chk("idle_ready", change_ready, 1);

        for (int v = 0; v < 11; v++) begin
            exp_n = vecs[v].n25 + vecs[v].n10 + vecs[v].n5;
            run_txn(vecs[v].amt, vecs[v].rf, rdy, lat, seq, n, ok);
            chk($sformatf("v%0d_ready", v), rdy, 1);
            chk($sformatf("v%0d_latency", v), lat, 2 + 5 * exp_n);
            chk($sformatf("v%0d_ncoins", v), n, exp_n);
            chk($sformatf("v%0d_order", v), seq, mkseq(vecs[v].n25, vecs[v].n10, vecs[v].n5));
            chk($sformatf("v%0d_pulse_shape", v), ok, 1);
            chk($sformatf("v%0d_short", v), short, vecs[v].sh);
            chk($sformatf("v%0d_remaining", v), remaining, vecs[v].rem);
            chk($sformatf("v%0d_inv25", v), inv_25, vecs[v].i25);
            chk($sformatf("v%0d_inv10", v), inv_10, vecs[v].i10);
            chk($sformatf("v%0d_inv5", v), inv_5, vecs[v].i5);
        end

        // Drain nickels, then 30 must pay only a 25 (no 10+10+10 fallback).
        all_ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            run_txn(8'd5, 1'b0, rdy, lat, seq, n, ok);
            if (!rdy || lat != 7 || n != 1 || seq[1:0] != 2'd3 || !ok || short) all_ok = 1'b0;
        end
        chk("nickel_drain_txns", all_ok, 1);
        chk("nickel_drain_inv5", inv_5, 0);
        run_txn(8'd30, 1'b0, rdy, lat, seq, n, ok);
        chk("greedy30_ncoins", n, 1);
        chk("greedy30_order", seq, mkseq(1, 0, 0));
        chk("greedy30_short", short, 1);
        chk("greedy30_remaining", remaining, 5);
        chk("greedy30_inv", {inv_25, inv_10, inv_5}, {6'd18, 6'd20, 6'd0});

        // Refill while busy is ignored.
        @(negedge clk);
        change_valid = 1'b1; change_amount = 8'd40;
        @(posedge clk);
        #1 change_valid = 1'b0;
        repeat (3) @(negedge clk);
        refill = 1'b1;
        repeat (4) @(negedge clk);
        refill = 1'b0;
        lat = -1;
        for (int c = 0; c < 60; c++) begin
            if (done) begin lat = c; break; end
            @(negedge clk);
        end
        chk("busy_refill_done_seen", lat >= 0, 1);
        chk("busy_refill_short", short, 1);
        chk("busy_refill_remaining", remaining, 5);
        chk("busy_refill_inv", {inv_25, inv_10, inv_5}, {6'd17, 6'd19, 6'd0});

        // Reset during the second cycle of the first pulse.
        @(negedge clk);
        change_valid = 1'b1; change_amount = 8'd40;
        @(posedge clk);
        #1 change_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midrst_pulse1", coin_out_25, 1);
        @(negedge clk);
        chk("midrst_pulse2", coin_out_25, 1);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_coin_low", {coin_out_25, coin_out_10, coin_out_5}, 0);
        chk("midrst_no_done_busy", {done, busy}, 0);
        chk("midrst_ready_low", change_ready, 0);
        chk("midrst_inv", {inv_25, inv_10, inv_5}, {6'd20, 6'd20, 6'd20});
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_ready_after", change_ready, 1);
        chk("midrst_no_done_after", done, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
